div_ctrl: RTL and testbench



---
 rtl/div_ctrl_pkg.sv | 24 ++
 rtl/div_step.sv | 22 ++
 rtl/div_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the M-extension divider: operand width, func3 codes,
// FSM state encodings and a small two's-complement helper.
package div_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? XLEN'((~v) + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor and keep the difference when it does not borrow.
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_msb_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            quo_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor keeps shifted below 2*divisor, so the top diff bit is a clean borrow
  assign shifted   = {rem_i, dvd_msb_i};
  assign diff      = shifted - {1'b0, divisor_i};
  assign quo_bit_o = ~diff[XLEN];
  assign rem_o     = quo_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU controller: stalls the pipeline while a
// 32-iteration restoring divide runs, then issues a single write-back pulse.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wr_en_o
);

  logic [1:0]      state_q,    state_d;
  logic [2:0]      func3_q,    func3_d;
  logic [XLEN-1:0] dvd_q,      dvd_d;
  logic [XLEN-1:0] dsr_q,      dsr_d;
  logic [XLEN-1:0] rem_q,      rem_d;
  logic [XLEN-1:0] quo_q,      quo_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic            neg_quo_q,  neg_quo_d;
  logic            neg_rem_q,  neg_rem_d;
  logic [4:0]      rd_q,       rd_d;
  logic [XLEN-1:0] result_q,   result_d;
  logic [4:0]      rd_addr_q,  rd_addr_d;
  logic            ready_q,    ready_d;

  logic            is_signed;
  logic            want_rem;
  logic            dvd_neg;
  logic            dsr_neg;
  logic [XLEN-1:0] step_rem;
  logic            step_bit;
  logic [XLEN-1:0] quo_next;

  div_step u_div_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[XLEN-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .quo_bit_o (step_bit)
  );

  assign is_signed = (func3_q == INST_DIV) || (func3_q == INST_REM);
  assign want_rem  = (func3_q == INST_REM) || (func3_q == INST_REMU);
  assign dvd_neg   = is_signed & dvd_q[XLEN-1];
  assign dsr_neg   = is_signed & dsr_q[XLEN-1];
  assign quo_next  = XLEN'({quo_q, step_bit});

  // Next-state and datapath updates; flush overrides everything but reset
  always_comb begin
    state_d   = state_q;
    func3_d   = func3_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rd_d      = rd_q;
    result_d  = result_q;
    rd_addr_d = rd_addr_q;
    ready_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          func3_d = func3_i;
          dvd_d   = dividend_i;
          dsr_d   = divisor_i;
          rd_d    = rd_addr_i;
          state_d = S_START;
        end
      end
      S_START: begin
        if (dsr_q == '0) begin
          result_d  = want_rem ? dvd_q : '1;
          rd_addr_d = rd_q;
          ready_d   = 1'b1;
          state_d   = S_END;
        end else if (is_signed && (dvd_q == INT_MIN) && (dsr_q == '1)) begin
          result_d  = want_rem ? '0 : INT_MIN;
          rd_addr_d = rd_q;
          ready_d   = 1'b1;
          state_d   = S_END;
        end else begin
          dvd_d     = neg_if(dvd_neg, dvd_q);
          dsr_d     = neg_if(dsr_neg, dsr_q);
          neg_quo_d = dvd_neg ^ dsr_neg;
          neg_rem_d = dvd_neg;
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = CNT_W'(XLEN);
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = quo_next;
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d  = want_rem ? neg_if(neg_rem_q, step_rem) : neg_if(neg_quo_q, quo_next);
          rd_addr_d = rd_q;
          ready_d   = 1'b1;
          state_d   = S_END;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush_i) begin
      state_d   = S_IDLE;
      result_d  = result_q;
      rd_addr_d = rd_addr_q;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      func3_q   <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      rd_addr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      func3_q   <= func3_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      rd_addr_q <= rd_addr_d;
      ready_q   <= ready_d;
    end
  end

  // Stall low in END so the instruction retires with its write-back
  assign hold_flag_o = ~flush_i &
                       (((state_q == S_IDLE) & start_i) | (state_q == S_START) | (state_q == S_CALC));
  assign busy_o      = (state_q != S_IDLE);
  assign ready_o     = ready_q;
  assign rd_wr_en_o  = ready_q;
  assign result_o    = result_q;
  assign rd_addr_o   = rd_addr_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, results, special cases, flush, reset
// and back-to-back issue against hand-computed values.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  func3_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        hold_flag_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wr_en_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  div_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .flush_i     (flush_i),
    .func3_i     (func3_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .rd_addr_i   (rd_addr_i),
    .busy_o      (busy_o),
    .hold_flag_o (hold_flag_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .rd_addr_o   (rd_addr_o),
    .rd_wr_en_o  (rd_wr_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue one request in the next cycle and observe it until ready (bounded)
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] res,
                       output logic [4:0] rda, output logic wen, output int hold_cnt,
                       output logic hold_end, output int rcyc);
    @(posedge clk); #1;
    start_i = 1'b1; func3_i = f3; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    #1;
    hold_cnt = hold_flag_o ? 1 : 0;
    lat = -1; res = 'x; rda = 'x; wen = 1'bx; hold_end = 1'bx; rcyc = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0; func3_i = ~f3; dividend_i = ~a; divisor_i = b + 32'd3; rd_addr_i = ~rd;
      #1;
      if (ready_o) begin
        lat = k; res = result_o; rda = rd_addr_o; wen = rd_wr_en_o;
        hold_end = hold_flag_o; rcyc = cyc;
      end else if (hold_flag_o) begin
        hold_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy_o, ready_o, rd_wr_en_o, hold_flag_o, result_o, rd_addr_o} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b ready=%b wen=%b hold=%b result=%h rd=%0d, required all 0",
               busy_o, ready_o, rd_wr_en_o, hold_flag_o, result_o, rd_addr_o);
    end
    rst = 1'b0;
  endtask

  task automatic run_table(input string tag, input vec_t v[$]);
    int lat, hc, rc;
    logic [31:0] res;
    logic [4:0] rda;
    logic wen, he;
    foreach (v[i]) begin
      do_op(v[i].f3, v[i].a, v[i].b, 5'(i + 3), lat, res, rda, wen, hc, he, rc);
      n_checks++;
      if (lat !== v[i].lat) begin
        n_fail++; $display("FAIL %s[%0d] latency: got %0d, required %0d", tag, i, lat, v[i].lat);
      end
      n_checks++;
      if (res !== v[i].exp) begin
        n_fail++; $display("FAIL %s[%0d] result: got %h, required %h", tag, i, res, v[i].exp);
      end
      n_checks++;
      if ({wen, rda} !== {1'b1, 5'(i + 3)}) begin
        n_fail++; $display("FAIL %s[%0d] wen/rd: got %b/%0d, required 1/%0d", tag, i, wen, rda, i + 3);
      end
      n_checks++;
      if ({hc, he} !== {v[i].lat, 1'b0}) begin
        n_fail++; $display("FAIL %s[%0d] hold: high %0d cycles, at END %b, required %0d and 0",
                           tag, i, hc, he, v[i].lat);
      end
    end
  endtask

  task automatic test_unsigned();
    vec_t v[$];
    v.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 34});
    v.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 34});
    v.push_back('{3'b101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34});
    v.push_back('{3'b101, 32'hFFFFFFFF, 32'h80000001, 32'd1, 34});
    v.push_back('{3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 34});
    run_table("unsigned", v);
  endtask

  task automatic test_signed();
    vec_t v[$];
    v.push_back('{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34});
    v.push_back('{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34});
    v.push_back('{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    v.push_back('{3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 34});
    run_table("signed", v);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 2});
    v.push_back('{3'b111, 32'd5, 32'd0, 32'd5, 2});
    v.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
    v.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2});
    v.push_back('{3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 2});
    run_table("special", v);
  endtask

  task automatic test_flush();
    int lat, hc, rc;
    logic [31:0] res;
    logic [4:0] rda;
    logic wen, he;
    logic seen;
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; func3_i = 3'b101; dividend_i = 32'd9; divisor_i = 32'd3;
    #1;
    n_checks++;
    if (hold_flag_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_hold: got %b, required 0", hold_flag_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_drop: busy %b, required 0", busy_o);
    end
    start_i = 1'b1; func3_i = 3'b101; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd12;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (k == 10) flush_i = 1'b1;
      #1;
      seen = seen | ready_o;
    end
    n_checks++;
    if ({hold_flag_o, busy_o} !== 2'b01) begin
      n_fail++; $display("FAIL flush_cycle: hold=%b busy=%b, required hold=0 busy=1", hold_flag_o, busy_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    seen = seen | ready_o;
    n_checks++;
    if ({busy_o, seen} !== 2'b00) begin
      n_fail++; $display("FAIL flush_abort: busy=%b ready_seen=%b, required 0 0", busy_o, seen);
    end
    do_op(3'b101, 32'hFFFFFFFF, 32'h10, 5'd13, lat, res, rda, wen, hc, he, rc);
    n_checks++;
    if ({lat, res, rda} !== {32'd34, 32'h0FFFFFFF, 5'd13}) begin
      n_fail++; $display("FAIL flush_reissue: lat=%0d result=%h rd=%0d, required 34 0fffffff 13", lat, res, rda);
    end
  endtask

  task automatic test_midop_reset();
    @(posedge clk); #1;
    start_i = 1'b1; func3_i = 3'b101; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd20;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, ready_o, rd_wr_en_o, hold_flag_o, result_o, rd_addr_o} !== 41'd0) begin
      n_fail++;
      $display("FAIL midop_reset: busy=%b ready=%b wen=%b hold=%b result=%h rd=%0d, required all 0",
               busy_o, ready_o, rd_wr_en_o, hold_flag_o, result_o, rd_addr_o);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [31:0] res;
    logic [4:0] rda;
    lat = -1; res = 'x; rda = 'x;
    @(posedge clk); #1;
    start_i = 1'b1; func3_i = 3'b100; dividend_i = 32'hFFFFFFF9; divisor_i = 32'd2; rd_addr_i = 5'd9;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      start_i = (k == 20);
      if (k == 20) begin
        func3_i = 3'b101; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd3;
      end
      #1;
      if (ready_o) begin
        lat = k; res = result_o; rda = rd_addr_o;
      end
    end
    n_checks++;
    if ({lat, res, rda} !== {32'd34, 32'hFFFFFFFD, 5'd9}) begin
      n_fail++; $display("FAIL ignore_start: lat=%0d result=%h rd=%0d, required 34 fffffffd 9", lat, res, rda);
    end
    @(posedge clk); #1; #1;
    n_checks++;
    if ({busy_o, ready_o, result_o} !== {2'b00, 32'hFFFFFFFD}) begin
      n_fail++; $display("FAIL after_end: busy=%b ready=%b result=%h, required 0 0 fffffffd",
                         busy_o, ready_o, result_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, hc, rc1, rc2;
    logic [31:0] res1, res2;
    logic [4:0] rda;
    logic wen, he;
    do_op(3'b101, 32'd100, 32'd7, 5'd1, lat1, res1, rda, wen, hc, he, rc1);
    do_op(3'b111, 32'd100, 32'd7, 5'd2, lat2, res2, rda, wen, hc, he, rc2);
    n_checks++;
    if ({res1, res2, rda} !== {32'd14, 32'd2, 5'd2}) begin
      n_fail++; $display("FAIL b2b_results: %0d %0d rd=%0d, required 14 2 rd=2", res1, res2, rda);
    end
    n_checks++;
    if (rc2 - rc1 !== 35 || rc1 < 0) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d cycles, required 35", rc2 - rc1);
    end
  endtask

  initial begin
    start_i = 1'b0; flush_i = 1'b0; func3_i = 3'b000;
    dividend_i = '0; divisor_i = '0; rd_addr_i = '0; rst = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_midop_reset();
    test_ignore_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
